gray_sync_decoder: RTL and testbench
====================================

GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the incoming Gray count and decoded binary.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops; legal range 2..4.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: gray_in  input  WIDTH  Gray-coded count from the upstream Gray counter; may be asynchronous to clk.
REQ-006 Port: bin_out  output  WIDTH  registered binary decode of the synchronized Gray value.
REQ-007 Port: bin_valid  output  1  high once the synchronizer pipeline holds post-reset samples.
REQ-008 Port: step_pulse  output  1  one-cycle pulse per legal single-bit Gray advance (+1 mod 2^WIDTH).
REQ-009 Port: wrap_pulse  output  1  one-cycle pulse when the decoded value advances from 2^WIDTH-1 to 0.
REQ-010 Port: err_flag  output  1  sticky flag for an illegal transition.
REQ-011 Port: err_count  output  8  saturating count of illegal transitions.

Function
REQ-012 Synchronizer: gray_in shifts through SYNC_STAGES flops; the last stage is the synchronized value g_s.
REQ-013 Decode: bin[WIDTH-1]=g_s[WIDTH-1]; bin[i]=bin[i+1] XOR g_s[i]; the result registers into bin_out.
REQ-014 Latency: a stable gray_in change appears on bin_out exactly SYNC_STAGES+1 clk edges later.
REQ-015 Warm-up counter: bin_valid asserts on the (SYNC_STAGES+1)th edge after reset deasserts and stays high until the next reset.
REQ-016 Compare register: a compare register g_prev holds g_s of the previous cycle; comparison is disabled while bin_valid is low.
REQ-017 No change: if g_s equals g_prev, no pulse is issued.
REQ-018 Legal step: if g_s differs from g_prev in exactly one bit and decode(g_s) equals decode(g_prev)+1 mod 2^WIDTH, step_pulse asserts for one cycle, aligned with the bin_out update.
REQ-019 Wrap: wrap_pulse asserts in the same cycle as step_pulse when decode(g_prev)=2^WIDTH-1 and decode(g_s)=0.
REQ-020 Illegal transition: any other change is illegal, including multi-bit changes and single-bit changes that decrement.
REQ-021 Illegal-transition response: no step_pulse; bin_out still follows the decode; err_flag sets; err_count increments.
REQ-022 Saturation: err_count saturates at 255.
REQ-023 Illegal-transition priority: an illegal transition never produces wrap_pulse.
REQ-024 Back-to-back legal steps on consecutive cycles produce consecutive step_pulse cycles with no gap.

Reset
REQ-025 While reset is high at a clk edge, the following clear to 0: all synchronizer stages, g_prev, bin_out, bin_valid, step_pulse, wrap_pulse, err_flag, err_count and the warm-up counter.
REQ-026 Reset mid-operation discards in-flight samples; the warm-up of REQ-015 restarts from zero.
REQ-027 A transition whose first half was sampled before reset is never reported after reset.

Configuration
REQ-028 With macro GRAY_SYNC_ERR_CHECK_EN defined, the illegal-transition logic of REQ-020 to REQ-023 is compiled in.
REQ-029 Without the macro, err_flag and err_count are held at constant 0 and remain present as ports.
REQ-030 Without the macro, an illegal transition still suppresses step_pulse and wrap_pulse, and bin_out still follows the decode.

Verification
REQ-031 Reset, then gray_in driven by the upstream 4-bit Gray counter for 40 cycles -> bin_out steps 0,1,...,15,0,... with each value 3 cycles after gray_in; one step_pulse per step; wrap_pulse at 15->0; err_count=0.
REQ-032 Release reset with gray_in=4'b0110 held -> bin_valid high on edge 3; bin_out=4; no step_pulse and no err_flag from the reset-to-first-sample transition.
REQ-033 With the macro defined, gray_in 0001->0010 (decode 1->3, two-bit change) -> err_flag=1; err_count=1; no step_pulse; bin_out=3.
REQ-034 With the macro defined, gray_in 0011->0001 (decode 2->1, decrement) -> err_count increments; no step_pulse; 300 such errors -> err_count=255.
REQ-035 Reset asserted for 1 cycle mid-count at bin_out=9 -> all outputs 0 on the next edge; bin_valid low for 3 cycles; counting resumes with no error reported.
REQ-036 Without the macro, repeat REQ-033 -> err_flag=0, err_count=0, no step_pulse, bin_out=3.

Source files
------------

// File: rtl/gray_sync_decoder.sv
// ============================================================================
// Module   : gray_sync_decoder
// Brief    : Synchronizes an asynchronous Gray count into clk, decodes it to
//            binary and flags legal +1 steps, wraps and illegal transitions.
//            Illegal-transition accounting is built only when the macro
//            GRAY_SYNC_ERR_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gray_sync_decoder #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_pulse,
   output logic             wrap_pulse,
   output logic             err_flag,
   output logic [7:0]       err_count
);

   localparam int             CNT_W     = 3;
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(SYNC_STAGES);

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] g_prev_q,     g_prev_d;
   logic [WIDTH-1:0] bin_out_q,    bin_out_d;
   logic [CNT_W-1:0] warm_cnt_q,   warm_cnt_d;
   logic             bin_valid_q,  bin_valid_d;
   logic             step_pulse_q, step_pulse_d;
   logic             wrap_pulse_q, wrap_pulse_d;

   logic [WIDTH-1:0] w_g_s;
   logic [WIDTH-1:0] w_dec_cur;
   logic [WIDTH-1:0] w_dec_prev;
   logic [WIDTH-1:0] w_dec_next;
   logic             w_legal;

   assign w_g_s      = sync_q[SYNC_STAGES-1];
   assign w_dec_cur  = gray2bin(w_g_s);
   assign w_dec_prev = gray2bin(g_prev_q);
   assign w_dec_next = w_dec_prev + WIDTH'(1);
   // Gating with bin_valid_q hides the reset-to-first-sample transition.
   assign w_legal    = bin_valid_q & $onehot(w_g_s ^ g_prev_q) & (w_dec_cur == w_dec_next);

   always_comb begin
      sync_d[0] = gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      g_prev_d     = w_g_s;
      bin_out_d    = w_dec_cur;
      warm_cnt_d   = (warm_cnt_q != WARM_LAST) ? warm_cnt_q + CNT_W'(1) : warm_cnt_q;
      bin_valid_d  = bin_valid_q | (warm_cnt_q == WARM_LAST);
      step_pulse_d = w_legal;
      wrap_pulse_d = w_legal & (w_dec_prev == '1) & (w_dec_cur == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         g_prev_q     <= '0;
         bin_out_q    <= '0;
         warm_cnt_q   <= '0;
         bin_valid_q  <= 1'b0;
         step_pulse_q <= 1'b0;
         wrap_pulse_q <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         g_prev_q     <= g_prev_d;
         bin_out_q    <= bin_out_d;
         warm_cnt_q   <= warm_cnt_d;
         bin_valid_q  <= bin_valid_d;
         step_pulse_q <= step_pulse_d;
         wrap_pulse_q <= wrap_pulse_d;
      end
   end

   assign bin_out    = bin_out_q;
   assign bin_valid  = bin_valid_q;
   assign step_pulse = step_pulse_q;
   assign wrap_pulse = wrap_pulse_q;

`ifdef GRAY_SYNC_ERR_CHECK_EN
   logic       err_flag_q,  err_flag_d;
   logic [7:0] err_count_q, err_count_d;
   logic       w_illegal;

   assign w_illegal = bin_valid_q & (w_g_s != g_prev_q) & ~w_legal;

   always_comb begin
      err_flag_d  = err_flag_q | w_illegal;
      err_count_d = err_count_q;
      if (w_illegal && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_flag_q  <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         err_flag_q  <= err_flag_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_flag  = err_flag_q;
   assign err_count = err_count_q;
`else
   assign err_flag  = 1'b0;
   assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_sync_decoder.sv
// ============================================================================
// Module   : tb_gray_sync_decoder
// Brief    : Scoreboard bench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gray_sync_decoder;

   typedef struct {
      logic [3:0] bin;
      logic       step;
      logic       wrap;
      logic       eflag;
      logic [7:0] ecnt;
   } exp_t;

   // Gray code of each binary value 0..15, indexed by the binary value.
   localparam logic [3:0] GRAY_TAB [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] gray_in = 4'h0;
   logic [3:0] bin_out;
   logic       bin_valid;
   logic       step_pulse;
   logic       wrap_pulse;
   logic       err_flag;
   logic [7:0] err_count;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q [$];

   logic [3:0] m_prev_g;
   logic       m_first = 1'b1;
   logic       m_eflag = 1'b0;
   logic [7:0] m_ecnt  = 8'd0;

   gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .gray_in    (gray_in),
      .bin_out    (bin_out),
      .bin_valid  (bin_valid),
      .step_pulse (step_pulse),
      .wrap_pulse (wrap_pulse),
      .err_flag   (err_flag),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   function automatic int g2b(input logic [3:0] g);
      for (int i = 0; i < 16; i++) begin
         if (GRAY_TAB[i] == g) return i;
      end
      return -1;
   endfunction

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1;
         exp_q.delete();
         m_first = 1'b1;
         m_eflag = 1'b0;
         m_ecnt  = 8'd0;
      end
   endtask

   task automatic drive(input logic [3:0] g);
      exp_t e;
      int   bc;
      int   bp;
      @(negedge clk);
      reset   = 1'b0;
      gray_in = g;
      bc      = g2b(g);
      e.bin   = bc[3:0];
      e.step  = 1'b0;
      e.wrap  = 1'b0;
      if (!m_first && (g != m_prev_g)) begin
         bp = g2b(m_prev_g);
         if (($countones(g ^ m_prev_g) == 1) && (bc == ((bp + 1) % 16))) begin
            e.step = 1'b1;
            e.wrap = (bp == 15);
         end else begin
`ifdef GRAY_SYNC_ERR_CHECK_EN
            m_eflag = 1'b1;
            if (m_ecnt != 8'd255) m_ecnt = m_ecnt + 8'd1;
`endif
         end
      end
      e.eflag  = m_eflag;
      e.ecnt   = m_ecnt;
      m_first  = 1'b0;
      m_prev_g = g;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expected entry for every cycle bin_valid is presented.
   initial begin
      int   since;
      exp_t e;
      since = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            since = 0;
            chk("reset_state", int'({bin_out, bin_valid, step_pulse, wrap_pulse, err_flag, err_count}), 0);
         end else begin
            since++;
            chk("bin_valid_timing", int'(bin_valid), int'(since >= 3));
            if (bin_valid !== 1'b1) begin
               chk("warmup_no_pulse", int'({step_pulse, wrap_pulse}), 0);
            end else if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("bin_out",    int'(bin_out),    int'(e.bin));
               chk("step_pulse", int'(step_pulse), int'(e.step));
               chk("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
               chk("err_flag",   int'(err_flag),   int'(e.eflag));
               chk("err_count",  int'(err_count),  int'(e.ecnt));
            end
         end
      end
   end

   initial begin
      do_reset(3);

      // Release with 0110 held: bin_out=4 on edge 3, no pulse or error.
      for (int i = 0; i < 6; i++) drive(4'b0110);

      // Upstream counter for 40 cycles, including 15->0 wraps.
      do_reset(1);
      for (int i = 0; i < 40; i++) drive(GRAY_TAB[i % 16]);

      // Mid-count reset while bin_out=9, then resume counting.
      do_reset(1);
      for (int i = 0; i < 12; i++) drive(GRAY_TAB[i]);
      do_reset(1);
      for (int i = 12; i < 24; i++) drive(GRAY_TAB[i % 16]);

      // Two-bit change 1->3.
      do_reset(1);
      for (int i = 0; i < 4; i++) drive(4'b0001);
      for (int i = 0; i < 4; i++) drive(4'b0010);

      // Illegal 14->0 must not look like a wrap.
      do_reset(1);
      for (int i = 0; i < 3; i++) drive(4'b1001);
      for (int i = 0; i < 3; i++) drive(4'b0000);

      // 300 decrements 2->1 to drive err_count into saturation.
      do_reset(1);
      for (int i = 0; i < 300; i++) begin
         drive(4'b0011);
         drive(4'b0001);
      end
      drive(4'b0001);
      drive(4'b0001);

      do_reset(1);
      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
